cap_scan_controller: RTL

- Sequences one shared capacitive_sensor measurement channel across NUM_PADS mole-hole pads in round-robin order.
- For each pad it clears the sensor, charges the pad, and opens a fixed sense window. It then latches the sensor's final_count and thresholds it into a per-pad touched bit.
- Sits between the pad I/O (charge drivers plus sensor_in mux) and the game logic, which consumes touched and scan_done.

---
 rtl/cap_scan_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cap_scan_controller.sv
// Round-robin capacitive scan sequencer: clears, charges and senses each pad in turn,
// then thresholds the sensor count into touched. Define CAP_SCAN_DEBOUNCE_EN for two-scan debounce.
module cap_scan_controller #(
    parameter int unsigned NUM_PADS       = 9,
    parameter int unsigned PAD_SEL_W      = 4,
    parameter int unsigned CHARGE_CYCLES  = 500,
    parameter int unsigned MEASURE_CYCLES = 5000,
    parameter int unsigned THRESHOLD      = 200
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [31:0]          final_count,
    output logic [PAD_SEL_W-1:0] pad_sel,
    output logic [NUM_PADS-1:0]  charge_out,
    output logic                 sensor_start,
    output logic                 capacitor_charged,
    output logic [NUM_PADS-1:0]  touched,
    output logic [31:0]          last_count,
    output logic                 scan_done
);

    localparam int unsigned MAX_CYC = (CHARGE_CYCLES > MEASURE_CYCLES) ? CHARGE_CYCLES : MEASURE_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [TIMER_W-1:0]   CHARGE_LAST = TIMER_W'(CHARGE_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   SENSE_LAST  = TIMER_W'(MEASURE_CYCLES - 1);
    localparam logic [PAD_SEL_W-1:0] LAST_PAD    = PAD_SEL_W'(NUM_PADS - 1);
    localparam logic [31:0]          THRESH      = 32'(THRESHOLD);

    typedef enum logic [2:0] {IDLE, CLEAR, CHARGE, SENSE, LATCH, NEXT} state_t;

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic                hit;
    logic [NUM_PADS-1:0] pad_onehot;
    logic [NUM_PADS-1:0] hit_vec;

    always_comb begin
        hit        = (final_count > THRESH);
        hit_vec    = {NUM_PADS{hit}};
        pad_onehot = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (pad_sel == PAD_SEL_W'(p)) pad_onehot[p] = 1'b1;
        end
    end

`ifdef CAP_SCAN_DEBOUNCE_EN
    logic [NUM_PADS-1:0] raw;
    logic [NUM_PADS-1:0] agree;

    // Only the selected pad may change, and only when this scan matches the previous raw sample.
    always_comb agree = ~(raw ^ hit_vec) & pad_onehot;
`endif

    // Outputs are registered, so each branch loads the values the next state presents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            timer             <= '0;
            pad_sel           <= '0;
            charge_out        <= '0;
            sensor_start      <= 1'b0;
            capacitor_charged <= 1'b0;
            touched           <= '0;
            last_count        <= '0;
            scan_done         <= 1'b0;
`ifdef CAP_SCAN_DEBOUNCE_EN
            raw               <= '0;
`endif
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    pad_sel           <= '0;
                    charge_out        <= '0;
                    sensor_start      <= 1'b0;
                    capacitor_charged <= 1'b0;
                    timer             <= '0;
                    if (enable) state <= CLEAR;
                end
                CLEAR: begin
                    sensor_start <= 1'b1;
                    charge_out   <= pad_onehot;
                    timer        <= '0;
                    state        <= CHARGE;
                end
                CHARGE: begin
                    if (timer == CHARGE_LAST) begin
                        timer             <= '0;
                        charge_out        <= '0;
                        capacitor_charged <= 1'b1;
                        state             <= SENSE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SENSE: begin
                    if (timer == SENSE_LAST) begin
                        timer             <= '0;
                        capacitor_charged <= 1'b0;
                        state             <= LATCH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LATCH: begin
                    last_count <= final_count;
`ifdef CAP_SCAN_DEBOUNCE_EN
                    raw        <= (raw & ~pad_onehot) | (hit_vec & pad_onehot);
                    touched    <= (touched & ~agree) | (hit_vec & agree);
`else
                    touched    <= (touched & ~pad_onehot) | (hit_vec & pad_onehot);
`endif
                    scan_done  <= (pad_sel == LAST_PAD);
                    state      <= NEXT;
                end
                NEXT: begin
                    pad_sel      <= (pad_sel == LAST_PAD) ? '0 : pad_sel + 1'b1;
                    sensor_start <= 1'b0;
                    state        <= enable ? CLEAR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
